// File: rtl/data_launch_pipe.sv
// ----------------------------------------------------------------------------
// data_launch_pipe
//
// Purpose:
//   Elastic launch pipeline with DEPTH register stages of WIDTH bits. Each
//   stage has its own valid bit. A stage advances when the stage ahead of it
//   is empty or is itself advancing, so bubbles collapse. A stalled output
//   therefore fills the upstream stages without losing throughput.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset; clears all stages and data
//   en         global enable; 0 freezes all stage state and both handshakes
//   flush      synchronous clear of all valid bits; data registers hold
//   in_valid   producer offers in_data
//   in_data    producer data [WIDTH]
//   in_ready   pipeline accepts in_data this cycle
//   out_valid  last stage holds valid data (masked during flush)
//   out_data   last-stage data [WIDTH]
//   out_ready  consumer accepts out_data
//   count      number of valid stages, 0..DEPTH [CNT_W]
// ----------------------------------------------------------------------------
module data_launch_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    logic [DEPTH-1:0] r_v;
    logic [WIDTH-1:0] r_d [DEPTH];
    logic [CNT_W-1:0] r_count;

    logic [DEPTH-1:0] w_mv;
    logic             w_out_fire;
    logic             w_in_fire;

    assign out_valid  = r_v[DEPTH-1] & ~flush;
    assign out_data   = r_d[DEPTH-1];
    assign w_out_fire = out_valid & out_ready & en;

    // Move chain, evaluated from the output side back to the input side.
    // A stage moves if it holds data and the next stage is free or is
    // moving this cycle. As a result, in_ready depends combinationally on
    // out_ready.
    always_comb begin
        w_mv          = '0;
        w_mv[DEPTH-1] = w_out_fire;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_mv[i] = en & r_v[i] & (~r_v[i+1] | w_mv[i+1]);
        end
    end

    assign in_ready  = en & ~flush & ~reset & (~r_v[0] | w_mv[0]);
    assign w_in_fire = in_valid & in_ready;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v     <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_d[i] <= '0;
            end
        end else if (flush) begin
            // Only the valids are dropped. The data registers keep stale contents.
            r_v     <= '0;
            r_count <= '0;
        end else begin
            if (w_in_fire) begin
                r_d[0] <= in_data;
                r_v[0] <= 1'b1;
            end else if (w_mv[0]) begin
                r_v[0] <= 1'b0;
            end

            for (int i = 1; i < DEPTH; i++) begin
                if (w_mv[i-1]) begin
                    r_d[i] <= r_d[i-1];
                    r_v[i] <= 1'b1;
                end else if (w_mv[i]) begin
                    r_v[i] <= 1'b0;
                end
            end

            case ({w_in_fire, w_out_fire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_launch_pipe.sv
// ----------------------------------------------------------------------------
// tb_data_launch_pipe
//
// Three pipelines share one set of producer and consumer inputs:
//   depth 3, depth 4 and depth 1, all with WIDTH = 4.
// The reference model treats each pipeline as an ordered list of words.
// Each word records its stage position. A word advances one position per
// enabled cycle, but never into the position its predecessor will occupy.
// The head word leaves when it sits at the last position and the consumer
// takes it.
// ----------------------------------------------------------------------------
module tb_data_launch_pipe;

    localparam int NI = 3;
    localparam int DEP [NI] = '{3, 4, 1};

    logic       clk;
    logic       reset;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic [3:0] in_data;
    logic       out_ready;

    logic       ir_a, ir_b, ir_c;
    logic       ov_a, ov_b, ov_c;
    logic [3:0] od_a, od_b, od_c;
    logic [1:0] cnt_a;
    logic [2:0] cnt_b;
    logic [0:0] cnt_c;

    logic       obs_ir  [NI];
    logic       obs_ov  [NI];
    logic [3:0] obs_od  [NI];
    logic [2:0] obs_cnt [NI];

    assign obs_ir[0]  = ir_a;
    assign obs_ir[1]  = ir_b;
    assign obs_ir[2]  = ir_c;
    assign obs_ov[0]  = ov_a;
    assign obs_ov[1]  = ov_b;
    assign obs_ov[2]  = ov_c;
    assign obs_od[0]  = od_a;
    assign obs_od[1]  = od_b;
    assign obs_od[2]  = od_c;
    assign obs_cnt[0] = {1'b0, cnt_a};
    assign obs_cnt[1] = cnt_b;
    assign obs_cnt[2] = {2'b00, cnt_c};

    data_launch_pipe #(.WIDTH(4), .DEPTH(3)) u_d3 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_a),
        .out_valid(ov_a), .out_data(od_a), .out_ready(out_ready), .count(cnt_a)
    );

    data_launch_pipe #(.WIDTH(4), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_b),
        .out_valid(ov_b), .out_data(od_b), .out_ready(out_ready), .count(cnt_b)
    );

    data_launch_pipe #(.WIDTH(4), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(ir_c),
        .out_valid(ov_c), .out_data(od_c), .out_ready(out_ready), .count(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: word list per pipeline, oldest word at index 0.
    int         m_n   [NI];
    int         m_pos [NI][4];
    logic [3:0] m_dat [NI][4];
    logic [3:0] m_last[NI];      // value currently held by the last stage
    int         m_np  [NI][4];   // positions after this cycle's moves
    bit         m_of  [NI];
    bit         m_if  [NI];

    int n_assert;
    int n_fail;

    // Predict and check the current cycle, then advance the model across
    // the next rising edge and return at the following falling edge.
    task automatic cycle();
        int  d;
        int  prev;
        bit  exp_ir;
        bit  exp_ov;
        int  m;
        #1;
        for (int k = 0; k < NI; k++) begin
            d      = DEP[k];
            exp_ir = 1'b0;
            exp_ov = (m_n[k] > 0) && (m_pos[k][0] == d - 1) && !flush;
            m_of[k] = 1'b0;
            for (int j = 0; j < 4; j++) m_np[k][j] = m_pos[k][j];
            if (!reset && !flush && en) begin
                m_of[k] = exp_ov && out_ready;
                prev = d;
                for (int j = 0; j < m_n[k]; j++) begin
                    if (j == 0 && m_of[k]) m_np[k][j] = d;
                    else m_np[k][j] = (m_pos[k][j] + 1 < prev - 1) ? m_pos[k][j] + 1 : prev - 1;
                    prev = m_np[k][j];
                end
                exp_ir = (m_n[k] == 0) || (m_np[k][m_n[k]-1] >= 1);
            end
            m_if[k] = exp_ir && in_valid;

            n_assert++;
            assert (obs_ir[k] === exp_ir) else begin
                n_fail++;
                $error("FAIL in_ready d%0d observed=%b expected=%b t=%0t", d, obs_ir[k], exp_ir, $time);
            end
            n_assert++;
            assert (obs_ov[k] === exp_ov) else begin
                n_fail++;
                $error("FAIL out_valid d%0d observed=%b expected=%b t=%0t", d, obs_ov[k], exp_ov, $time);
            end
            n_assert++;
            assert (obs_od[k] === m_last[k]) else begin
                n_fail++;
                $error("FAIL out_data d%0d observed=%h expected=%h t=%0t", d, obs_od[k], m_last[k], $time);
            end
            n_assert++;
            assert (obs_cnt[k] === 3'(m_n[k])) else begin
                n_fail++;
                $error("FAIL count d%0d observed=%0d expected=%0d t=%0t", d, obs_cnt[k], m_n[k], $time);
            end
        end

        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            d = DEP[k];
            if (reset) begin
                m_n[k]    = 0;
                m_last[k] = 4'h0;
            end else if (flush) begin
                m_n[k] = 0;
            end else if (en) begin
                m = 0;
                for (int j = 0; j < m_n[k]; j++) begin
                    if (!(j == 0 && m_of[k])) begin
                        if (m_np[k][j] == d - 1 && m_pos[k][j] != d - 1) m_last[k] = m_dat[k][j];
                        m_pos[k][m] = m_np[k][j];
                        m_dat[k][m] = m_dat[k][j];
                        m++;
                    end
                end
                if (m_if[k]) begin
                    m_pos[k][m] = 0;
                    m_dat[k][m] = in_data;
                    if (d == 1) m_last[k] = in_data;
                    m++;
                end
                m_n[k] = m;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        for (int k = 0; k < NI; k++) begin
            m_n[k]    = 0;
            m_last[k] = 4'h0;
        end

        // Reset and idle.
        reset     = 1'b1;
        en        = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();

        // Back-to-back streaming of 1..10 with the consumer always ready.
        in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = 4'(i);
            cycle();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Backpressure: offer 5,6,7,8 while the consumer stalls, then release.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 5; i <= 8; i++) begin
            in_data = 4'(i);
            cycle();
        end
        cycle();
        cycle();
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Bubble collapse: alternate in_valid with the consumer stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 4'(4'h9 + i);
            cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // Enable stall in the middle of a stream.
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 4'($urandom);
            en      = !(i >= 4 && i < 7);
            cycle();
        end
        en       = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();

        // Flush with two words held and a word on offer.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'hA;
        cycle();
        in_data   = 4'hB;
        cycle();
        in_data   = 4'hC;
        flush     = 1'b1;
        cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        cycle();
        out_ready = 1'b1;
        cycle();
        cycle();

        // Randomised traffic, including enable stalls, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            en        = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            reset     = ($urandom_range(0, 79) == 0);
            in_data   = 4'($urandom);
            cycle();
        end
        reset    = 1'b0;
        flush    = 1'b0;
        en       = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_launch_pipe.md
Name: data_launch_pipe

Overview:
- Parametrised elastic launch pipeline: DEPTH register stages of WIDTH bits, each stage carrying its own valid bit.
- valid/ready handshakes on both ends, plus a global enable (stall), a synchronous flush and an occupancy count.
- Bubbles collapse, so a stalled output fills upstream stages without losing throughput.
- Sits between a producer datapath and a consumer capture stage, replacing fixed-width single-stage enable registers.

Parameters:
- WIDTH, 4, data width in bits (>=1).
- DEPTH, 2, number of pipeline stages (>=1).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  global enable; 0 freezes all stage state and blocks both handshakes.
- flush  input  1  synchronous clear of all valid bits.
- in_valid  input  1  producer offers in_data.
- in_data  input  WIDTH  producer data.
- in_ready  output  1  pipeline accepts in_data this cycle.
- out_valid  output  1  last stage holds valid data.
- out_data  output  WIDTH  last-stage data.
- out_ready  input  1  consumer accepts out_data.
- count  output  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- Reset (highest priority):
  - All stage valids, stage data, out_valid, out_data and count are 0.
  - in_ready is 0 while reset is high.
  - Reset mid-transfer discards all contents; nothing is emitted.
- Stage indices run 0 (input side) to DEPTH-1 (output side); v[i] and d[i] are registers.
- out_valid = v[DEPTH-1] & ~flush. out_data = d[DEPTH-1].
- out_fire = out_valid & out_ready & en.
- mv[DEPTH-1] = out_fire. For i < DEPTH-1: mv[i] = en & v[i] & (~v[i+1] | mv[i+1]).
- in_ready = en & ~flush & ~reset & (~v[0] | mv[0]).
  - in_ready depends combinationally on out_ready through the mv chain. This is accepted; no registered-ready mode exists in this block.
- in_fire = in_valid & in_ready.
- Per clock edge, when not reset and not flush:
  - Stage i>0 loads d[i-1] and sets v[i] when mv[i-1]. Otherwise it clears v[i] if mv[i]; otherwise it holds.
  - Stage 0 loads in_data and sets v[0] on in_fire. Otherwise it clears v[0] if mv[0].
  - Data registers change only on load; an emptied stage keeps stale data.
- en=0: no stage changes, no handshake completes, count holds.
  - out_valid still reflects v[DEPTH-1].
  - The consumer must not treat out_valid & out_ready as a transfer while en=0.
- flush=1 (not reset):
  - All v[] clear at the edge; data registers hold; count becomes 0.
  - in_ready and out_valid are 0 during the flush cycle, so nothing is accepted or emitted.
  - flush acts regardless of en.
- Latency:
  - A word accepted at edge N (pipeline empty, en=1, out_ready=1) makes out_valid=1 after edge N+DEPTH-1, i.e. DEPTH cycles after the accept cycle.
  - For DEPTH=1, out_valid rises the cycle after acceptance.
- Throughput: one word per cycle sustained when out_ready=1 and en=1, for every DEPTH including 1.
- Backpressure:
  - With out_ready=0, the pipeline absorbs exactly DEPTH words, then in_ready=0.
  - When out_ready returns to 1, in_ready is 1 in that same cycle (simultaneous accept and emit).
- Ordering: strictly FIFO. No duplication or loss except by flush or reset.
- count: registered. Next value = count + in_fire - out_fire, or 0 on reset/flush. It always equals the popcount of v[].

Test Plan:
- Reset/idle: WIDTH=4, DEPTH=3; assert reset 2 cycles -> out_valid=0, out_data=0, count=0, in_ready=0 during reset and 1 after.
- Streaming latency: DEPTH=3, out_ready=1, en=1, push 0x1,0x2,...,0xA back-to-back -> 0x1 emerges 3 cycles after acceptance, then one word per cycle in order, count peaks at 3.
- Backpressure fill/drain: DEPTH=3, out_ready=0, push 0x5,0x6,0x7,0x8 -> first three accepted, count=3, in_ready=0 holding 0x8. Raise out_ready -> 0x8 accepted in the same cycle 0x5 emits; output order is 0x5,0x6,0x7,0x8.
- Bubble collapse: DEPTH=4, alternate in_valid 1/0 with out_ready=0 for 8 cycles -> 4 words accepted, no gaps, emitted contiguously once out_ready=1.
- Enable stall: mid-stream drop en for 3 cycles -> no stage changes, in_ready=0, count constant; the stream resumes intact after en=1.
- Flush and DEPTH=1: with 2 words held, pulse flush while in_valid=1 -> word not accepted, out_valid=0 that cycle and after, count=0. Repeat streaming at DEPTH=1 -> full throughput with 1-cycle latency.
